simd_mul_result_collector: RTL

- Consumer end of the SIMD multiplier's result valid/ready interface.
- Accepts 64-bit multiplier results for one instruction at a time and buffers them in a small FIFO.
- Issues byte-enabled write requests to the lane VRF port, with a request/grant handshake.
- Counts the bytes of the instruction and pulses done once the last write is granted, so the lane sequencer can retire the instruction.

---
 rtl/simd_mul_result_collector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/simd_mul_result_collector.sv
// Small synchronous FIFO with registered storage and a head view.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: the caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_vld,
    input  logic [Width-1:0]        push_dat,
    input  logic                    pop_vld,
    output logic [Width-1:0]        head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(Depth):0]  cnt
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_vld, pop_vld})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt_q == CntW'(Depth));
    assign empty    = (cnt_q == '0);
    assign cnt      = cnt_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_vld && full));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_vld && empty));
endmodule

// Collects SIMD multiplier results for one instruction and writes them to the lane VRF.
// Latency: accepted result reaches vrf_req_o one cycle later; done_o one cycle after last grant.
// Backpressure: ready_o drops while the FIFO is full (independent of vrf_gnt_i) or all bytes are in.
module simd_mul_result_collector #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 insn_valid_i,
    output logic                 insn_ready_o,
    input  logic [CntWidth-1:0]  insn_vl_bytes_i,
    input  logic [AddrWidth-1:0] insn_vd_addr_i,
    input  logic [63:0]          result_i,
    input  logic [7:0]           mask_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 vrf_req_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    output logic [63:0]          vrf_wdata_o,
    output logic [7:0]           vrf_be_o,
    input  logic                 vrf_gnt_i,
    output logic                 done_o
);
    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  be;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    localparam int unsigned FifoCntW = $clog2(Depth) + 1;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  rx_rem_q, beat_bytes;
    logic [AddrWidth-1:0] wr_addr_q;
    logic [7:0]           tail_mask;
    logic                 insn_acc, zero_len, push, pop, last_beat, drain_done;
    logic                 fifo_full, fifo_empty, done_q, done_zl_q;
    logic [FifoCntW-1:0]  fifo_cnt;
    entry_t               push_entry, head_entry;

    assign zero_len   = (insn_vl_bytes_i == '0);
    assign insn_acc   = insn_valid_i && insn_ready_o;
    assign push       = valid_i && ready_o;
    assign pop        = vrf_req_o && vrf_gnt_i;
    assign tail_mask  = (rx_rem_q >= CntWidth'(8)) ? 8'hFF : ((8'd1 << rx_rem_q[2:0]) - 8'd1);
    assign beat_bytes = (rx_rem_q >= CntWidth'(8)) ? CntWidth'(8) : rx_rem_q;
    assign last_beat  = push && (rx_rem_q <= CntWidth'(8));
    // DRAIN finishes in the cycle the FIFO is (or is about to become) empty.
    assign drain_done = (state_q == DRAIN) &&
                        (fifo_empty || ((fifo_cnt == FifoCntW'(1)) && pop));

    assign push_entry.dat = result_i;
    assign push_entry.be  = mask_i & tail_mask;

    sync_fifo #(
        .Width ($bits(entry_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_vld  (pop),
        .head_dat (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (insn_acc && !zero_len) state_d = ACTIVE;
            ACTIVE:  if (last_beat)             state_d = DRAIN;
            DRAIN:   if (drain_done)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        insn_ready_o = 1'b0;
        ready_o      = 1'b0;
        case (state_q)
            IDLE:    insn_ready_o = 1'b1;
            ACTIVE:  ready_o      = !fifo_full && (rx_rem_q != '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_rem_q  <= '0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            done_zl_q <= 1'b0;
        end else begin
            if (insn_acc)  rx_rem_q <= insn_vl_bytes_i;
            else if (push) rx_rem_q <= rx_rem_q - beat_bytes;
            if (insn_acc)  wr_addr_q <= insn_vd_addr_i;
            else if (pop)  wr_addr_q <= wr_addr_q + AddrWidth'(8);
            done_q    <= (insn_acc && zero_len) || drain_done;
            done_zl_q <= insn_acc && zero_len;
        end
    end

    assign vrf_req_o   = !fifo_empty;
    assign vrf_addr_o  = wr_addr_q;
    assign vrf_wdata_o = vrf_req_o ? head_entry.dat : 64'd0;
    assign vrf_be_o    = vrf_req_o ? head_entry.be  : 8'd0;
    assign done_o      = done_q;

    // Back-to-back done is only legal when the second one comes from a zero-length instruction.
    assert property (@(posedge clk_i) disable iff (!rst_ni) (done_q && $past(done_q)) |-> done_zl_q);
endmodule
